// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every output comes straight from a register; the FSM state is also exported for debug.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy,
    output logic       TxD_done,
    output logic [2:0] o_dbg_state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_txd;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [BW-1:0]   w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_par_nxt;
    logic            w_txd_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_tick;

    assign w_tick = (r_baud == BAUD_LAST);

    // Next values are computed one cycle ahead so TxD/busy/done can be registered
    // without adding a cycle of latency to the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + BAUD_ONE;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_busy_nxt = 1'b0;
                if (TxD_start && !r_busy) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = TxD_data;
                    w_par_nxt   = (PARITY == 2) ? ~^TxD_data : ^TxD_data;
                    w_txd_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                w_txd_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                w_txd_nxt = r_shift[0];
                if (w_tick) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt = 3'd0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_txd_nxt   = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_txd_nxt = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                w_txd_nxt = r_par;
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                // The bit counter is reused to count stop bits.
                if (r_bit == STOP_LAST && r_baud == BAUD_PRE) begin
                    w_done_nxt = 1'b1;
                end
                if (w_tick) begin
                    w_baud_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = 3'd0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = 3'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign TxD         = r_txd;
    assign TxD_busy    = r_busy;
    assign TxD_done    = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide asynchronous serial transmitter: the stage directly downstream of the transmit control unit. It accepts a byte on a TxD_start request while idle and shifts it out on TxD as a standard UART frame. Framing is a start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It reports TxD_busy for the whole frame, so the control unit can sequence the LSB and MSB bytes of each FIR result.

## Interface
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range ≥ 2
- STOP_BITS, 1, number of stop bits; legal values 1 or 2
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- TxD_start  input  1  transmit request, level-sampled each cycle
- TxD_data  input  8  byte to send, captured on acceptance
- TxD  output  1  serial line; idles high
- TxD_busy  output  1  high from the cycle after acceptance until the frame ends
- TxD_done  output  1  one-cycle pulse in the last cycle of the final stop bit

## Operation
- All outputs are registered.
- Reset values: TxD = 1, TxD_busy = 0, TxD_done = 0. State = IDLE; bit counter and baud counter = 0.
- Acceptance: a request is accepted in a cycle where TxD_start = 1 and state = IDLE with TxD_busy = 0.
  - TxD_data is copied into the shift register that cycle.
  - Later changes to TxD_data are ignored until the next acceptance.
- A TxD_start asserted while busy is ignored. It is not queued.
- A TxD_start held high continuously produces back-to-back frames.
- States:
  - IDLE: TxD = 1. Moves to START on acceptance.
  - START: TxD = 0 for CLKS_PER_BIT cycles. Then moves to DATA.
  - DATA: TxD = shift_reg[0] for CLKS_PER_BIT cycles per bit, 8 bits, LSB first. After bit 7, moves to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: TxD = ^data for even parity, ~^data for odd parity, for CLKS_PER_BIT cycles. Then moves to STOP.
  - STOP: TxD = 1 for STOP_BITS × CLKS_PER_BIT cycles. Then moves to IDLE.
- Baud counter: counts 0 … CLKS_PER_BIT−1. It wraps to 0 at each bit boundary and is cleared on acceptance. Its width is $clog2(CLKS_PER_BIT).
- Bit counter: 3 bits. It counts data bits 0 … 7 and is cleared on entry to DATA.
- Parity is computed from the captured byte, not from live TxD_data.
- Reset mid-frame aborts the frame. In the next cycle TxD = 1 and TxD_busy = 0. No TxD_done pulse is generated.

## Timing
- Let acceptance occur in cycle N and let C = CLKS_PER_BIT.
- Start bit: TxD_busy = 1 and TxD = 0 from cycle N+1. The start bit occupies cycles N+1 … N+C.
- Data bit i (0–7): occupies cycles N+1+(i+1)C … N+(i+2)C.
- Parity bit, when enabled: occupies cycles N+1+9C … N+10C.
- Stop bits: begin at cycle N+1+(9+P)C, where P = 1 if parity is enabled, else 0.
- TxD_done = 1 in cycle N+(9+P+STOP_BITS)C. This is the last stop cycle.
- In cycle N+1+(9+P+STOP_BITS)C: TxD_busy = 0, TxD = 1, state = IDLE.
  - A TxD_start in this same cycle is accepted.
  - The next start bit then begins one cycle later.
  - Minimum inter-frame idle gap is therefore exactly 1 cycle.
- Frame length in busy cycles: (10+P+STOP_BITS−1)·C + … ; exactly (9+P+STOP_BITS)·C.
- TxD changes only at bit boundaries. No glitches within a bit.

## Test plan
- Reset check. C=4, STOP_BITS=1, PARITY=0. Hold rst for 3 cycles, then release → TxD=1, TxD_busy=0, TxD_done=0. Outputs stay there with TxD_start=0.
- Basic frame. C=4, STOP_BITS=1, PARITY=0. Send 0xA5.
  - Required TxD: 4 cycles of 0, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 4 cycles of 1.
  - TxD_busy is high for exactly 40 cycles. TxD_done pulses once in the 40th cycle.
- Start while busy. Send 0x3C, then pulse TxD_start with TxD_data=0xFF mid-frame → frame is exactly 0x3C with no corruption. No second frame is sent.
- Back-to-back frames. Hold TxD_start=1 with TxD_data=0x00, then 0xFF after the first acceptance → two frames, 0x00 then 0xFF. Exactly 1 idle-high cycle separates the stop bit of frame 1 from the start bit of frame 2.
- Parity and stop bits. C=4, PARITY=2 (odd), STOP_BITS=2. Send 0x07 → parity bit = 0. TxD_busy lasts 48 cycles. Stop level is 8 cycles high.
- Reset mid-frame. Assert rst during data bit 3 of 0x55 → the next cycle has TxD=1 and TxD_busy=0, with no TxD_done. A subsequent 0x55 frame is sent correctly.
